// File: rtl/kp_pkg.sv
// Shared types and matrix geometry for the 4x4 keypad scanner.
package kp_pkg;

    localparam int KP_ROWS  = 4;
    localparam int KP_COLS  = 4;
    localparam int KP_KEYS  = KP_ROWS * KP_COLS;
    localparam int KP_ROW_W = $clog2(KP_ROWS);
    localparam int KP_COL_W = $clog2(KP_COLS);

    typedef enum logic [1:0] {
        KP_IDLE,
        KP_DRIVE,
        KP_SAMPLE,
        KP_COMPARE
    } kp_state_t;

    // Active-low one-cold drive pattern for the selected column.
    function automatic logic [KP_COLS-1:0] col_drive(input logic [KP_COL_W-1:0] col);
        logic [KP_COLS-1:0] one_hot;
        one_hot = '0;
        one_hot[col] = 1'b1;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer bringing asynchronous keypad rows into the clk domain.
module sync2 #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: non-blocking assignments make r_meta -> r_sync a real two-stage pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, samples the rows
// after a settle delay and commits a key map once it repeats over several scans.
module keypad_scanner
    import kp_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [KP_ROWS-1:0]  row_in,
    output logic [KP_COLS-1:0]  col_out,
    output logic [KP_KEYS-1:0]  keys,
    output logic                key_event,
    output logic                scan_done
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [SET_W-1:0]    SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [DEB_W-1:0]    DEB_TARGET  = DEB_W'(DEBOUNCE_SCANS);
    localparam logic [KP_COL_W-1:0] COL_LAST    = KP_COL_W'(KP_COLS - 1);

    kp_state_t            r_state;
    kp_state_t            w_next_state;
    logic [KP_COL_W-1:0]  r_col;
    logic [SET_W-1:0]     r_settle;
    logic [KP_KEYS-1:0]   r_raw;
    logic [KP_KEYS-1:0]   r_cand;
    logic [DEB_W-1:0]     r_count;
    logic [KP_KEYS-1:0]   r_keys;
    logic                 r_key_event;

    logic [KP_ROWS-1:0]   w_row_sync;
    logic [KP_ROWS-1:0]   w_row_s;
    logic [KP_KEYS-1:0]   w_cand_next;
    logic [DEB_W-1:0]     w_count_next;
    logic                 w_commit;
    logic [KP_COLS-1:0]   w_col_out;
    logic                 w_scan_done;

    // Rows idle high through the pull-ups, so the synchronizer resets to all ones.
    sync2 #(
        .WIDTH     (KP_ROWS),
        .RESET_VAL ({KP_ROWS{1'b1}})
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .i_d (row_in),
        .o_q (w_row_sync)
    );

    assign w_row_s = ~w_row_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= KP_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        if (!enable) begin
            w_next_state = KP_IDLE;
        end else begin
            unique case (r_state)
                KP_IDLE:    w_next_state = KP_DRIVE;
                KP_DRIVE:   if (r_settle == SETTLE_LAST) w_next_state = KP_SAMPLE;
                KP_SAMPLE:  w_next_state = (r_col == COL_LAST) ? KP_COMPARE : KP_DRIVE;
                KP_COMPARE: w_next_state = KP_DRIVE;
                default:    w_next_state = KP_IDLE;
            endcase
        end
    end

    always_comb begin
        w_col_out   = '1;
        w_scan_done = 1'b0;
        unique case (r_state)
            KP_DRIVE,
            KP_SAMPLE:  w_col_out   = col_drive(r_col);
            KP_COMPARE: w_scan_done = enable;
            default:    w_col_out   = '1;
        endcase
    end

    // Debounce: count consecutive identical scans, saturating at the target.
    always_comb begin
        w_cand_next  = r_cand;
        w_count_next = r_count;
        if (r_raw != r_cand) begin
            w_cand_next  = r_raw;
            w_count_next = DEB_W'(1);
        end else if (r_count < DEB_TARGET) begin
            w_count_next = r_count + DEB_W'(1);
        end
        w_commit = (w_count_next == DEB_TARGET) && (w_cand_next != r_keys);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col       <= '0;
            r_settle    <= '0;
            r_raw       <= '0;
            r_cand      <= '0;
            r_count     <= '0;
            r_keys      <= '0;
            r_key_event <= 1'b0;
        end else begin
            r_key_event <= 1'b0;
            if (!enable) begin
                // Abandon the partial scan; the committed map is kept.
                r_col    <= '0;
                r_settle <= '0;
                r_raw    <= '0;
                r_cand   <= '0;
                r_count  <= '0;
            end else begin
                unique case (r_state)
                    KP_IDLE: begin
                        r_col    <= '0;
                        r_settle <= '0;
                    end
                    KP_DRIVE: begin
                        if (r_settle == SETTLE_LAST) begin
                            r_settle <= '0;
                        end else begin
                            r_settle <= r_settle + SET_W'(1);
                        end
                    end
                    KP_SAMPLE: begin
                        for (int r = 0; r < KP_ROWS; r++) begin
                            r_raw[{KP_ROW_W'(r), r_col}] <= w_row_s[r];
                        end
                        if (r_col != COL_LAST) begin
                            r_col <= r_col + KP_COL_W'(1);
                        end
                    end
                    KP_COMPARE: begin
                        r_col    <= '0;
                        r_settle <= '0;
                        r_cand   <= w_cand_next;
                        r_count  <= w_count_next;
                        if (w_commit) begin
                            r_keys      <= w_cand_next;
                            r_key_event <= 1'b1;
                        end
                    end
                    default: begin
                        r_col    <= '0;
                        r_settle <= '0;
                    end
                endcase
            end
        end
    end

    assign col_out   = w_col_out;
    assign scan_done = w_scan_done;
    assign keys      = r_keys;
    assign key_event = r_key_event && enable;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: keypad matrix model driven scan by scan, with a
// history-based debounce reference model.
module tb_keypad_scanner;

    localparam int SETTLE   = 2;
    localparam int DEB      = 3;
    localparam int SCAN_LEN = 4 * (SETTLE + 1) + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] keys;
    logic        key_event;
    logic        scan_done;

    logic [15:0] key_map;

    int n_checks = 0;
    int n_pass   = 0;
    int n_events = 0;

    logic [15:0] m_keys;
    bit          m_pending;
    logic [15:0] m_hist[$];

    keypad_scanner #(
        .SETTLE_CYCLES  (SETTLE),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .row_in    (row_in),
        .col_out   (col_out),
        .keys      (keys),
        .key_event (key_event),
        .scan_done (scan_done)
    );

    always #5 clk = ~clk;

    // A held key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(key_map[r*4 +: 4] & ~col_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // A map is accepted when the last DEB completed scans since the last
    // clear all read the same value and it differs from the current map.
    task automatic model_scan(input logic [15:0] raw);
        bool_all_equal: begin
            bit same;
            m_hist.push_back(raw);
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
            same = (m_hist.size() == DEB);
            foreach (m_hist[k]) if (m_hist[k] != raw) same = 0;
            if (same && raw != m_keys) begin
                m_keys    = raw;
                m_pending = 1;
            end
        end
    endtask

    // Runs n cycles of a scan from its start, checking every cycle.
    task automatic scan_cycles(input logic [15:0] km, input int n);
        logic [3:0] exp_col;
        key_map = km;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_col = (i < SCAN_LEN - 1) ? ~(4'b0001 << (i / (SETTLE + 1))) : 4'hF;
            check("col_out", col_out, exp_col);
            check("scan_done", scan_done, i == SCAN_LEN - 1);
            check("key_event", key_event, (i == 0) && m_pending);
            check("keys", keys, m_keys);
            if (key_event) n_events++;
            if (i == 0) m_pending = 0;
        end
        if (n == SCAN_LEN) model_scan(km);
    endtask

    task automatic disable_for(input int idle);
        enable = 1'b0;
        m_hist.delete();
        for (int i = 0; i < idle; i++) begin
            @(negedge clk);
            check("idle_col", col_out, 4'hF);
            check("idle_scan_done", scan_done, 1'b0);
            check("idle_key_event", key_event, 1'b0);
            check("idle_keys", keys, m_keys);
        end
        enable = 1'b1;
    endtask

    function automatic logic [15:0] rand_map();
        logic [15:0] one;
        one = 16'h0001;
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return one << $urandom_range(0, 15);
            2:       return (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int e0;
        logic [15:0] km;
        rst       = 1'b1;
        enable    = 1'b0;
        key_map   = 16'h0000;
        m_keys    = 16'h0000;
        m_pending = 0;
        repeat (3) @(negedge clk);
        check("rst_col", col_out, 4'hF);
        check("rst_keys", keys, 16'h0000);
        check("rst_key_event", key_event, 1'b0);
        check("rst_scan_done", scan_done, 1'b0);
        rst = 1'b0;
        disable_for(3);

        // Rows floating: column stepping and scan_done period.
        scan_cycles(16'h0000, SCAN_LEN);
        scan_cycles(16'h0000, SCAN_LEN);

        // Hold (1,2): commit after the third matching scan, exactly once.
        disable_for(2);
        e0 = n_events;
        scan_cycles(16'h0040, SCAN_LEN);
        scan_cycles(16'h0040, SCAN_LEN);
        check("hold_before_commit", keys, 16'h0000);
        scan_cycles(16'h0040, SCAN_LEN);
        scan_cycles(16'h0040, SCAN_LEN);
        check("hold_commit", keys, 16'h0040);
        scan_cycles(16'h0040, SCAN_LEN);
        scan_cycles(16'h0040, SCAN_LEN);
        check("hold_one_event", n_events - e0, 1);

        // Release with bounce: no event until three clean released scans.
        e0 = n_events;
        scan_cycles(16'h0000, SCAN_LEN);
        scan_cycles(16'h0040, SCAN_LEN);
        scan_cycles(16'h0000, SCAN_LEN);
        scan_cycles(16'h0000, SCAN_LEN);
        check("release_bouncing", keys, 16'h0040);
        check("release_no_event", n_events - e0, 0);
        scan_cycles(16'h0000, SCAN_LEN);
        scan_cycles(16'h0000, SCAN_LEN);
        check("release_commit", keys, 16'h0000);
        check("release_one_event", n_events - e0, 1);

        // One-scan bounce on (0,0) is rejected; two keys together commit.
        e0 = n_events;
        scan_cycles(16'h0001, SCAN_LEN);
        repeat (4) scan_cycles(16'h0000, SCAN_LEN);
        check("bounce_keys", keys, 16'h0000);
        check("bounce_no_event", n_events - e0, 0);
        repeat (4) scan_cycles(16'h8001, SCAN_LEN);
        check("two_keys", keys, 16'h8001);

        // Disable during column 1 drive while (1,2) is held.
        repeat (4) scan_cycles(16'h0040, SCAN_LEN);
        check("pre_disable", keys, 16'h0040);
        e0 = n_events;
        scan_cycles(16'h0040, 4);
        disable_for(3);
        repeat (4) scan_cycles(16'h0040, SCAN_LEN);
        check("reenable_keys", keys, 16'h0040);
        check("reenable_no_event", n_events - e0, 0);

        // Asynchronous reset mid-scan, seen before any clock edge.
        scan_cycles(16'h0040, 7);
        #2 rst = 1'b1;
        #1;
        check("async_rst_col", col_out, 4'hF);
        check("async_rst_keys", keys, 16'h0000);
        check("async_rst_key_event", key_event, 1'b0);
        m_keys    = 16'h0000;
        m_pending = 0;
        m_hist.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) scan_cycles(16'h0040, SCAN_LEN);
        check("post_rst_keys", keys, 16'h0040);

        // Randomized scans with occasional mid-scan disables.
        km = 16'h0040;
        for (int it = 0; it < 70; it++) begin
            if ($urandom_range(0, 99) < 35) km = rand_map();
            if ($urandom_range(0, 9) == 0) begin
                scan_cycles(km, $urandom_range(2, SCAN_LEN - 1));
                disable_for($urandom_range(1, 4));
            end else begin
                scan_cycles(km, SCAN_LEN);
            end
        end
        scan_cycles(km, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
